huffman_gen: RTL and testbench
==============================

# huffman_gen

Parametrised Huffman front end: counts symbol occurrences over one input frame, then builds a prefix-free code for `NSYM` symbols by merging the two lightest nodes each cycle. It generalises the fixed 6-symbol counter/encoder in symbol count and counter width. It adds input back-pressure, counter saturation and a held, handshaked result. It sits between the symbol source and the code-table writer.

## Interface
- `NSYM`, 6: number of symbols, at least 2; symbol values are 1..NSYM.
- `CNT_W`, 8: count width per symbol; counts saturate at 2^CNT_W-1.
- `SYM_W`, $clog2(NSYM+1): symbol input width (derived).
- `LMAX`, NSYM-1: maximum code length (derived).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: symbol beat valid; a frame is a contiguous run of valid beats.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `in_sym` in SYM_W: symbol; values 0 and >NSYM are accepted but not counted.
- `cnt_valid` out 1: one-cycle pulse; `cnt` is valid in that cycle.
- `cnt` out NSYM*CNT_W: symbol k count in slice [k*CNT_W +: CNT_W], k = sym-1.
- `code_valid` out 1: result valid; held until accepted.
- `code_ready` in 1: result accepted when `code_valid & code_ready`.
- `hc` out NSYM*LMAX: symbol k code bits; bit L-1 is the root-side MSB; zero above length.
- `hm` out NSYM*LMAX: symbol k mask; the low L bits are set, where L is the code length.

## Operation
- States: IDLE, COUNT, BUILD, HOLD.
- IDLE:
  - `in_ready`=1; counters are cleared every cycle without a beat.
  - An accepted beat is counted and moves the block to COUNT.
- COUNT:
  - `in_ready`=1; each accepted beat increments its symbol counter, saturating.
  - The first cycle with `in_valid`=0 ends the frame and moves the block to BUILD.
- BUILD:
  - `in_ready`=0. Node set is initialised to NSYM leaves; leaf weight = count, zero counts included.
  - Each cycle merges the two smallest nodes, one merge per cycle, NSYM-1 cycles total.
  - Smallest node (A): every member symbol gets bit 1 at position = its current depth.
  - Second node (B): every member symbol gets bit 0 at the same position.
  - All members of A and B get a mask bit set at that position and depth +1.
  - Merged node weight = sum of the two weights; members = union of both member sets.
- Ordering, total and deterministic: lower weight first.
  - On equal weight, a merged node precedes a leaf.
  - Among merged nodes, the most recently created comes first.
  - Among leaves, the higher symbol index comes first.
- Weight width is CNT_W+$clog2(NSYM); no overflow is possible.
- After the last merge the block enters HOLD. `code_valid`=1 and `hc`/`hm` stay stable until `code_ready`.
- On handshake the block returns to IDLE; counters are cleared there.
- `in_valid` during BUILD/HOLD is ignored and not counted (`in_ready`=0).

## Timing
- Reset (async): state IDLE; all counters, codes and masks 0.
  - Output reset values: `in_ready`=1, `cnt_valid`=0, `code_valid`=0, `cnt`/`hc`/`hm`=0.
- Reset mid-frame, mid-BUILD or in HOLD aborts the operation; there is no partial output.
- If the first `in_valid`=0 is at cycle T:
  - BUILD runs T+1..T+NSYM-1.
  - `cnt_valid` pulses at T+1 with final counts; `cnt` reads 0 in all other cycles.
  - `code_valid` rises at T+NSYM.
- `hc`/`hm` read 0 whenever `code_valid`=0.
- With `code_ready` held high, `code_valid` lasts exactly one cycle and `in_ready` returns at T+NSYM+1.
- A one-beat frame is legal. Back-to-back frames need at least one idle cycle between them; the gap itself ends the frame.

## Structure
- Package `huffman_pkg`: state enum `hg_state_e`.
- Package `huffman_pkg`: function `node_less`, the ordering compare on {weight, is_leaf, creation order, symbol index}.
- Sub-module `huffman_min2`: combinational, parametrised by NSYM; takes node keys plus a live mask and returns indices of the smallest and second-smallest live nodes.
- Top level holds the FSM, counters, node registers, code/mask registers and handshake.

## Test plan
All scenarios use NSYM=6, CNT_W=8.
- Frame with counts 1,2,3,4,5,6 for symbols 1..6 -> `cnt_valid` shows 1..6.
  - hc = 07,06,02,03,02,00 (hex).
  - hm = 0F,0F,07,03,03,03.
- One-beat frame of symbol 3 -> counts 0,0,1,0,0,0.
  - hc = 02,06,00,0E,1E,1F.
  - hm = 03,07,01,0F,1F,1F.
- 300 beats of symbol 2 interleaved with symbols 0 and 7 -> count2=255 (saturated); all other counts 0; ignored symbols not counted.
- `code_ready` low for 10 cycles after `code_valid` -> `hc`/`hm` stable, `in_ready`=0, `in_valid` pulses not counted; IDLE one cycle after acceptance.
- Assert `rst_n` low during cycle 3 of BUILD -> all outputs at reset values immediately. A next frame with counts 1..6 reproduces scenario 1 exactly.
- Two frames separated by one idle cycle -> the second frame's counts exclude the first frame's beats; latency T+1 / T+NSYM holds for both.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and the node ordering rule for the Huffman front end.
package huffman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_BUILD = 2'd2,
        ST_HOLD  = 2'd3
    } hg_state_e;

    localparam int KEY_W = 32;
    localparam int TAG_W = 8;

    // Total order: lighter first; on a tie merged nodes beat leaves, newer merged
    // nodes beat older ones, and higher-index leaves beat lower ones.
    function automatic logic node_less(
        input logic [KEY_W-1:0] weight_a,
        input logic             leaf_a,
        input logic [TAG_W-1:0] order_a,
        input logic [TAG_W-1:0] sym_a,
        input logic [KEY_W-1:0] weight_b,
        input logic             leaf_b,
        input logic [TAG_W-1:0] order_b,
        input logic [TAG_W-1:0] sym_b
    );
        logic less;
        if (weight_a != weight_b)
            less = (weight_a < weight_b);
        else if (leaf_a != leaf_b)
            less = !leaf_a;
        else if (!leaf_a)
            less = (order_a > order_b);
        else
            less = (sym_a > sym_b);
        return less;
    endfunction

endpackage

// File: rtl/huffman_min2.sv
// Combinational selection of the smallest and second-smallest live nodes.
module huffman_min2
    import huffman_pkg::*;
#(
    parameter int NSYM = 6,
    parameter int WW   = 11,
    parameter int IW   = $clog2(NSYM)
) (
    input  logic [NSYM*WW-1:0] weight,
    input  logic [NSYM-1:0]    leaf,
    input  logic [NSYM*IW-1:0] order,
    input  logic [NSYM-1:0]    live,
    output logic [IW-1:0]      idx_a,
    output logic [IW-1:0]      idx_b
);

    logic [WW-1:0] w   [NSYM];
    logic [IW-1:0] ord [NSYM];

    for (genvar g = 0; g < NSYM; g++) begin : g_unpack
        assign w[g]   = weight[g*WW +: WW];
        assign ord[g] = order[g*IW +: IW];
    end

    always_comb begin
        logic found_a;
        logic found_b;
        idx_a   = '0;
        idx_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (live[i] && (!found_a ||
                node_less(KEY_W'(w[i]), leaf[i], TAG_W'(ord[i]), TAG_W'(i),
                          KEY_W'(w[idx_a]), leaf[idx_a], TAG_W'(ord[idx_a]), TAG_W'(idx_a)))) begin
                idx_a   = IW'(i);
                found_a = 1'b1;
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            if (live[i] && (IW'(i) != idx_a) && (!found_b ||
                node_less(KEY_W'(w[i]), leaf[i], TAG_W'(ord[i]), TAG_W'(i),
                          KEY_W'(w[idx_b]), leaf[idx_b], TAG_W'(ord[idx_b]), TAG_W'(idx_b)))) begin
                idx_b   = IW'(i);
                found_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/huffman_gen.sv
// Huffman front end: per-frame symbol counting, then one tree merge per cycle
// into held prefix-code/mask registers released through a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | waiting for the first beat; counters cleared each beat-free cycle
// ST_COUNT | frame in progress; first cycle without a beat ends it
// ST_BUILD | NSYM-1 merge cycles, input stalled
// ST_HOLD  | codes presented until accepted
module huffman_gen
    import huffman_pkg::*;
#(
    parameter  int NSYM  = 6,
    parameter  int CNT_W = 8,
    localparam int SYM_W = $clog2(NSYM + 1),
    localparam int LMAX  = NSYM - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYM_W-1:0]      in_sym,
    output logic                  cnt_valid,
    output logic [NSYM*CNT_W-1:0] cnt,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic [NSYM*LMAX-1:0]  hc,
    output logic [NSYM*LMAX-1:0]  hm
);

    localparam int WW = CNT_W + $clog2(NSYM);
    localparam int IW = $clog2(NSYM);
    localparam logic [IW-1:0] LAST_STEP = IW'(NSYM - 2);

    hg_state_e        state;
    logic [IW-1:0]    step;
    logic [CNT_W-1:0] cnt_r  [NSYM];
    logic [WW-1:0]    wt     [NSYM];
    logic [IW-1:0]    ord    [NSYM];
    logic [NSYM-1:0]  mem    [NSYM];
    logic [NSYM-1:0]  leaf;
    logic [NSYM-1:0]  live;
    logic [LMAX-1:0]  hc_r   [NSYM];
    logic [LMAX-1:0]  hm_r   [NSYM];
    logic [LMAX-1:0]  pos    [NSYM];

    logic                 beat;
    logic                 frame_end;
    logic [NSYM*WW-1:0]   wt_flat;
    logic [NSYM*IW-1:0]   ord_flat;
    logic [IW-1:0]        idx_a;
    logic [IW-1:0]        idx_b;

    assign in_ready   = (state == ST_IDLE) || (state == ST_COUNT);
    assign beat       = in_valid & in_ready;
    assign frame_end  = (state == ST_COUNT) && !in_valid;
    assign cnt_valid  = (state == ST_BUILD) && (step == '0);
    assign code_valid = (state == ST_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (beat)
                        state <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (!in_valid) begin
                        state <= ST_BUILD;
                        step  <= '0;
                    end
                end
                ST_BUILD: begin
                    step <= step + 1'b1;
                    if (step == LAST_STEP)
                        state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (code_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The first IDLE beat overwrites rather than increments, so stale counts
    // from the previous frame never leak into a frame that starts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSYM; k++)
                cnt_r[k] <= '0;
        end else begin
            for (int k = 0; k < NSYM; k++) begin
                if (state == ST_IDLE)
                    cnt_r[k] <= (beat && in_sym == SYM_W'(k + 1)) ? CNT_W'(1) : '0;
                else if (state == ST_COUNT && beat && in_sym == SYM_W'(k + 1) && cnt_r[k] != '1)
                    cnt_r[k] <= cnt_r[k] + 1'b1;
            end
        end
    end

    always_comb begin
        wt_flat  = '0;
        ord_flat = '0;
        for (int i = 0; i < NSYM; i++) begin
            wt_flat[i*WW +: WW]  = wt[i];
            ord_flat[i*IW +: IW] = ord[i];
        end
    end

    huffman_min2 #(
        .NSYM (NSYM),
        .WW   (WW),
        .IW   (IW)
    ) u_min2 (
        .weight (wt_flat),
        .leaf   (leaf),
        .order  (ord_flat),
        .live   (live),
        .idx_a  (idx_a),
        .idx_b  (idx_b)
    );

    // Merged node reuses slot A; leaves never move, so a leaf's slot is its symbol index.
    // pos is a per-symbol one-hot of the next code bit, i.e. the symbol's current depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf <= '0;
            live <= '0;
            for (int i = 0; i < NSYM; i++) begin
                wt[i]   <= '0;
                ord[i]  <= '0;
                mem[i]  <= '0;
                hc_r[i] <= '0;
                hm_r[i] <= '0;
                pos[i]  <= '0;
            end
        end else if (frame_end) begin
            leaf <= '1;
            live <= '1;
            for (int i = 0; i < NSYM; i++) begin
                wt[i]   <= WW'(cnt_r[i]);
                ord[i]  <= '0;
                mem[i]  <= NSYM'(1) << i;
                hc_r[i] <= '0;
                hm_r[i] <= '0;
                pos[i]  <= LMAX'(1);
            end
        end else if (state == ST_BUILD) begin
            wt[idx_a]   <= wt[idx_a] + wt[idx_b];
            ord[idx_a]  <= step + 1'b1;
            mem[idx_a]  <= mem[idx_a] | mem[idx_b];
            leaf[idx_a] <= 1'b0;
            live[idx_b] <= 1'b0;
            for (int s = 0; s < NSYM; s++) begin
                if (mem[idx_a][s]) begin
                    hc_r[s] <= hc_r[s] | pos[s];
                    hm_r[s] <= hm_r[s] | pos[s];
                    pos[s]  <= pos[s] << 1;
                end else if (mem[idx_b][s]) begin
                    hm_r[s] <= hm_r[s] | pos[s];
                    pos[s]  <= pos[s] << 1;
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        hc  = '0;
        hm  = '0;
        for (int k = 0; k < NSYM; k++) begin
            if (cnt_valid)
                cnt[k*CNT_W +: CNT_W] = cnt_r[k];
            if (code_valid) begin
                hc[k*LMAX +: LMAX] = hc_r[k];
                hm[k*LMAX +: LMAX] = hm_r[k];
            end
        end
    end

endmodule

// File: tb/tb_huffman_gen.sv
// Directed bench for huffman_gen (NSYM=6, CNT_W=8) with hand-derived codes.
module tb_huffman_gen;

    localparam int NSYM  = 6;
    localparam int CNT_W = 8;
    localparam int SYM_W = 3;
    localparam int LMAX  = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [SYM_W-1:0]      in_sym;
    logic                  cnt_valid;
    logic [NSYM*CNT_W-1:0] cnt;
    logic                  code_valid;
    logic                  code_ready;
    logic [NSYM*LMAX-1:0]  hc;
    logic [NSYM*LMAX-1:0]  hm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    huffman_gen #(.NSYM(NSYM), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sym     (in_sym),
        .cnt_valid  (cnt_valid),
        .cnt        (cnt),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .hc         (hc),
        .hm         (hm)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pk5(input logic [4:0] c1, c2, c3, c4, c5, c6);
        return {c6, c5, c4, c3, c2, c1};
    endfunction

    function automatic logic [47:0] pk8(input logic [7:0] n1, n2, n3, n4, n5, n6);
        return {n6, n5, n4, n3, n2, n1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SYM_W-1:0] s);
        in_valid = 1'b1;
        in_sym   = s;
        tick();
    endtask

    task automatic frame_ramp();
        for (int k = 1; k <= NSYM; k++)
            for (int j = 0; j < k; j++)
                beat(SYM_W'(k));
    endtask

    // Called in the cycle right after the last beat (cycle T).
    task automatic finish_frame(input string nm, input logic [47:0] ecnt,
                                input logic [29:0] ehc, input logic [29:0] ehm);
        in_valid = 1'b0;
        in_sym   = '0;
        check({nm, "_cv_at_T"}, 64'(cnt_valid), 64'd0);
        tick();
        check({nm, "_cv_T1"}, 64'(cnt_valid), 64'd1);
        check({nm, "_cnt"}, 64'(cnt), 64'(ecnt));
        check({nm, "_ready_build"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < NSYM - 2; i++) begin
            tick();
            check({nm, "_build_quiet"}, 64'({code_valid, cnt_valid, (cnt != '0), in_ready}), 64'd0);
        end
        tick();
        check({nm, "_code_valid"}, 64'(code_valid), 64'd1);
        check({nm, "_hc"}, 64'(hc), 64'(ehc));
        check({nm, "_hm"}, 64'(hm), 64'(ehm));
        if (code_ready) begin
            tick();
            check({nm, "_cv_drop"}, 64'(code_valid), 64'd0);
            check({nm, "_ready_back"}, 64'(in_ready), 64'd1);
            check({nm, "_hc_zero"}, 64'(hc), 64'd0);
        end
    endtask

    logic [29:0] ramp_hc, ramp_hm, one_hc, one_hm, sat_hc, sat_hm;

    initial begin
        ramp_hc = pk5(5'h07, 5'h06, 5'h02, 5'h03, 5'h02, 5'h00);
        ramp_hm = pk5(5'h0F, 5'h0F, 5'h07, 5'h03, 5'h03, 5'h03);
        one_hc  = pk5(5'h02, 5'h06, 5'h00, 5'h0E, 5'h1E, 5'h1F);
        one_hm  = pk5(5'h03, 5'h07, 5'h01, 5'h0F, 5'h1F, 5'h1F);
        sat_hc  = pk5(5'h02, 5'h00, 5'h06, 5'h0E, 5'h1E, 5'h1F);
        sat_hm  = pk5(5'h03, 5'h01, 5'h07, 5'h0F, 5'h1F, 5'h1F);

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sym     = '0;
        code_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_flags", 64'({cnt_valid, code_valid}), 64'd0);
        check("rst_data", 64'({cnt != '0, hc != '0, hm != '0}), 64'd0);
        #13;
        rst_n = 1'b1;
        tick();

        // counts 1..6, then a one-beat frame starting in the first IDLE cycle
        frame_ramp();
        finish_frame("ramp", pk8(1, 2, 3, 4, 5, 6), ramp_hc, ramp_hm);
        beat(3'd3);
        finish_frame("one", pk8(0, 0, 1, 0, 0, 0), one_hc, one_hm);

        // saturation with out-of-range symbols mixed in
        for (int i = 0; i < 300; i++) begin
            beat(3'd2);
            beat(3'd0);
            beat(3'd7);
        end
        finish_frame("sat", pk8(0, 255, 0, 0, 0, 0), sat_hc, sat_hm);

        // result held under back-pressure
        tick();
        code_ready = 1'b0;
        frame_ramp();
        finish_frame("hold", pk8(1, 2, 3, 4, 5, 6), ramp_hc, ramp_hm);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_sym   = 3'd4;
            tick();
            check("hold_cv", 64'(code_valid), 64'd1);
            check("hold_stable", 64'({hc, hm}), 64'({ramp_hc, ramp_hm}));
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid   = 1'b0;
        code_ready = 1'b1;
        tick();
        check("hold_accept_cv", 64'(code_valid), 64'd0);
        check("hold_accept_idle", 64'(in_ready), 64'd1);

        // reset during the third BUILD cycle
        tick();
        frame_ramp();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midbuild_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_flags", 64'({cnt_valid, code_valid}), 64'd0);
        check("abort_data", 64'({cnt != '0, hc != '0, hm != '0}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame_ramp();
        finish_frame("after_rst", pk8(1, 2, 3, 4, 5, 6), ramp_hc, ramp_hm);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
